// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and helpers for the sequential ALU.
// ROL/ROR opcodes exist only when ALU_ROTATE_EN is defined.
package alu_pkg;

   localparam logic [5:0] OP_ADD  = 6'd0;
   localparam logic [5:0] OP_AND  = 6'd1;
   localparam logic [5:0] OP_OR   = 6'd2;
   localparam logic [5:0] OP_SUB  = 6'd3;
   localparam logic [5:0] OP_XOR  = 6'd4;
   localparam logic [5:0] OP_SLT  = 6'd5;
   localparam logic [5:0] OP_NOR  = 6'd6;
   localparam logic [5:0] OP_SLL  = 6'd7;
   localparam logic [5:0] OP_MULU = 6'd8;
   localparam logic [5:0] OP_MULS = 6'd9;
   localparam logic [5:0] OP_SRL  = 6'd10;
   localparam logic [5:0] OP_SRA  = 6'd11;
   localparam logic [5:0] OP_SLTU = 6'd12;
`ifdef ALU_ROTATE_EN
   localparam logic [5:0] OP_ROL  = 6'd13;
   localparam logic [5:0] OP_ROR  = 6'd14;
`endif

   typedef enum logic [1:0] {StIdle, StMul, StFix} state_e;

   function automatic logic is_mul(input logic [5:0] op);
      return (op == OP_MULU) || (op == OP_MULS);
   endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle on operand magnitudes,
// with the sign restored combinationally on the held product.
module alu_seq_mul #(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               mul_signed,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int unsigned CntW = $clog2(WIDTH);

   logic [WIDTH-1:0]   mcand_q, acc_q, mplier_q, a_mag, b_mag;
   logic               neg_q, run_q;
   logic [CntW-1:0]    cnt_q;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] raw;

   // Magnitude of the most-negative value still fits as an unsigned WIDTH-bit number.
   always_comb begin
      a_mag   = (mul_signed && a[WIDTH-1]) ? -a : a;
      b_mag   = (mul_signed && b[WIDTH-1]) ? -b : b;
      sum     = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
      raw     = {acc_q, mplier_q};
      product = neg_q ? -raw : raw;
      done    = run_q && (cnt_q == CntW'(WIDTH - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         neg_q    <= 1'b0;
         cnt_q    <= '0;
         run_q    <= 1'b0;
      end else if (start) begin
         mcand_q  <= a_mag;
         mplier_q <= b_mag;
         acc_q    <= '0;
         neg_q    <= mul_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
         cnt_q    <= '0;
         run_q    <= 1'b1;
      end else if (run_q) begin
         acc_q    <= sum[WIDTH:1];
         mplier_q <= {sum[0], mplier_q[WIDTH-1:1]};
         cnt_q    <= cnt_q + 1'b1;
         if (done) run_q <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops load the output registers at acceptance, multiplies
// run through alu_seq_mul. Define ALU_ROTATE_EN to add the ROL/ROR opcodes.
module alu_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [5:0]       op,
   input  logic [SHW-1:0]   shamt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             carry,
   output logic             overflow,
   output logic             busy
);

   state_e             state_q, state_d;
   logic               accept, mul_start, mul_done, mul_signed_q, mul_ovf;
   logic [2*WIDTH-1:0] mul_product;
   logic [WIDTH-1:0]   sc_res, result_q, result_hi_q;
   logic               sc_carry, sc_ovf, zero_q, carry_q, ovf_q, out_valid_q;
   logic [WIDTH:0]     add_full, sub_full;
`ifdef ALU_ROTATE_EN
   logic [2*WIDTH-1:0] rot;
`endif

   assign in_ready  = (state_q == StIdle) && (!out_valid_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign mul_start = accept && is_mul(op);
   assign busy      = (state_q != StIdle);

   always_comb begin
      add_full = {1'b0, a} + {1'b0, b};
      sub_full = {1'b0, a} - {1'b0, b};
      sc_res   = '0;
      sc_carry = 1'b0;
      sc_ovf   = 1'b0;
`ifdef ALU_ROTATE_EN
      rot      = '0;
`endif
      case (op)
         OP_ADD: begin
            sc_res   = add_full[WIDTH-1:0];
            sc_carry = add_full[WIDTH];
            sc_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            sc_res   = sub_full[WIDTH-1:0];
            sc_carry = sub_full[WIDTH];
            sc_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  sc_res = a & b;
         OP_OR:   sc_res = a | b;
         OP_XOR:  sc_res = a ^ b;
         OP_NOR:  sc_res = ~(a | b);
         OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, a < b};
         OP_SLL:  sc_res = a << shamt;
         OP_SRL:  sc_res = a >> shamt;
         OP_SRA:  sc_res = $signed(a) >>> shamt;
`ifdef ALU_ROTATE_EN
         OP_ROL: begin
            rot    = {a, a} << shamt;
            sc_res = rot[2*WIDTH-1:WIDTH];
         end
         OP_ROR: begin
            rot    = {a, a} >> shamt;
            sc_res = rot[WIDTH-1:0];
         end
`endif
         default: ;
      endcase
   end

   assign mul_ovf = mul_signed_q
                  ? (mul_product[2*WIDTH-1:WIDTH] != {WIDTH{mul_product[WIDTH-1]}})
                  : (mul_product[2*WIDTH-1:WIDTH] != '0);

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (mul_start) state_d = StMul;
         StMul:   if (mul_done) state_d = StFix;
         StFix:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         mul_signed_q <= 1'b0;
         out_valid_q  <= 1'b0;
         result_q     <= '0;
         result_hi_q  <= '0;
         zero_q       <= 1'b0;
         carry_q      <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         state_q <= state_d;
         if (mul_start) mul_signed_q <= (op == OP_MULS);
         if (accept && !is_mul(op)) begin
            result_q    <= sc_res;
            result_hi_q <= '0;
            zero_q      <= (sc_res == '0);
            carry_q     <= sc_carry;
            ovf_q       <= sc_ovf;
            out_valid_q <= 1'b1;
         end else if (state_q == StFix) begin
            result_q    <= mul_product[WIDTH-1:0];
            result_hi_q <= mul_product[2*WIDTH-1:WIDTH];
            zero_q      <= (mul_product == '0);
            carry_q     <= 1'b0;
            ovf_q       <= mul_ovf;
            out_valid_q <= 1'b1;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign result_hi = result_hi_q;
   assign zero      = zero_q;
   assign carry     = carry_q;
   assign overflow  = ovf_q;

   alu_seq_mul #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk        (clk),
      .rst        (rst),
      .start      (mul_start),
      .mul_signed (op == OP_MULS),
      .a          (a),
      .b          (b),
      .done       (mul_done),
      .product    (mul_product)
   );

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): scoreboard of model results checked on output.
module tb_alu_seq;

   localparam int W = 8;

   typedef logic [2*W+2:0] exp_t;  // {hi, lo, zero, carry, overflow}
   typedef struct packed {
      logic [5:0]   o;
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic [2:0]   s;
   } stim_t;

   logic         clk = 1'b0;
   logic         rst, in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0] a, b, result, result_hi;
   logic [5:0]   op;
   logic [2:0]   shamt;
   logic         zero, carry, overflow, busy;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   stim_t single_tab [17] = '{
      '{6'd0, 8'h7F, 8'h01, 3'd0}, '{6'd3, 8'h05, 8'h07, 3'd0}, '{6'd3, 8'h07, 8'h07, 3'd0},
      '{6'd11, 8'h80, 8'h00, 3'd3}, '{6'd1, 8'hF0, 8'h3C, 3'd0}, '{6'd2, 8'hF0, 8'h0F, 3'd0},
      '{6'd4, 8'hAA, 8'hFF, 3'd0}, '{6'd6, 8'h0F, 8'h30, 3'd0}, '{6'd5, 8'h80, 8'h01, 3'd0},
      '{6'd12, 8'h80, 8'h01, 3'd0}, '{6'd7, 8'h81, 8'h00, 3'd1}, '{6'd10, 8'h81, 8'h00, 3'd7},
      '{6'd7, 8'h5A, 8'h00, 3'd0}, '{6'd0, 8'hFF, 8'h01, 3'd0}, '{6'd3, 8'h80, 8'h01, 3'd0},
      '{6'h3F, 8'h12, 8'h34, 3'd2}, '{6'd13, 8'hA5, 8'h00, 3'd3}
   };
   exp_t single_pin [4] = '{
      {8'h00, 8'h80, 3'b001}, {8'h00, 8'hFE, 3'b010},
      {8'h00, 8'h00, 3'b100}, {8'h00, 8'hF0, 3'b000}
   };
   stim_t mul_tab [4] = '{
      '{6'd9, 8'hFD, 8'h05, 3'd0}, '{6'd8, 8'hFF, 8'hFF, 3'd0},
      '{6'd9, 8'h80, 8'h80, 3'd0}, '{6'd9, 8'h7F, 8'h81, 3'd0}
   };
   exp_t mul_pin [3] = '{
      {8'hFF, 8'hF1, 3'b000}, {8'hFE, 8'h01, 3'b001}, {8'h40, 8'h00, 3'b001}
   };

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .shamt     (shamt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .result_hi (result_hi),
      .zero      (zero),
      .carry     (carry),
      .overflow  (overflow),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic exp_t model(input logic [5:0] o, input logic [7:0] x, input logic [7:0] y,
                                  input logic [2:0] s);
      int          ia, ib, sa, sb2, p;
      logic [7:0]  lo, hi;
      logic [15:0] p16;
      logic        c, v;
      ia = int'(x); ib = int'(y); sa = int'($signed(x)); sb2 = int'($signed(y));
      lo = 8'h00; hi = 8'h00; c = 1'b0; v = 1'b0; p = 0; p16 = 16'h0;
      case (o)
         6'd0: begin
            p = ia + ib; lo = p[7:0]; c = (p > 255);
            p = sa + sb2; v = (p > 127) || (p < -128);
         end
         6'd3: begin
            p = ia - ib; lo = p[7:0]; c = (ia < ib);
            p = sa - sb2; v = (p > 127) || (p < -128);
         end
         6'd1:  lo = x & y;
         6'd2:  lo = x | y;
         6'd4:  lo = x ^ y;
         6'd6:  lo = ~(x | y);
         6'd5:  lo = (sa < sb2) ? 8'h01 : 8'h00;
         6'd12: lo = (ia < ib) ? 8'h01 : 8'h00;
         6'd7:  begin p = ia << s; lo = p[7:0]; end
         6'd10: begin p = ia >> s; lo = p[7:0]; end
         6'd11: begin p = sa >>> s; lo = p[7:0]; end
         6'd8:  begin p = ia * ib; p16 = p[15:0]; lo = p16[7:0]; hi = p16[15:8]; v = (hi != 0); end
         6'd9:  begin
            p = sa * sb2; p16 = p[15:0]; lo = p16[7:0]; hi = p16[15:8];
            v = (p > 127) || (p < -128);
         end
`ifdef ALU_ROTATE_EN
         6'd13: begin p = (ia << s) | (ia >> (8 - s)); lo = p[7:0]; end
         6'd14: begin p = (ia >> s) | (ia << (8 - s)); lo = p[7:0]; end
`endif
         default: ;
      endcase
      return {hi, lo, ({hi, lo} == 16'h0), c, v};
   endfunction

   function automatic exp_t observed();
      return {result_hi, result, zero, carry, overflow};
   endfunction

   task automatic send(input logic [5:0] o, input logic [7:0] x, input logic [7:0] y,
                       input logic [2:0] s);
      bit acc = 1'b0;
      op = o; a = x; b = y; shamt = s; in_valid = 1'b1;
      sb.push_back(model(o, x, y, s));
      for (int n = 0; n < 40; n++) begin
         #1;
         if (in_ready) begin acc = 1'b1; break; end
         @(negedge clk);
      end
      if (!acc) begin
         checks++; errors++;
         $display("FAIL send_accept: in_ready got 0 want 1 within 40 cycles");
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int edges);
      edges = 0;
      #1;
      while (!out_valid && edges < 40) begin
         @(negedge clk); #1; edges++;
      end
      if (!out_valid) begin
         checks++; errors++;
         $display("FAIL wait_out: out_valid got 0 want 1 within 40 cycles");
      end
   endtask

   task automatic test_reset();
      logic [22:0] got;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; op = '0; shamt = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      got = {out_valid, in_ready, busy, result, result_hi, zero, carry, overflow};
      checks++;
      if (got !== {3'b010, 8'h00, 8'h00, 3'b000}) begin
         errors++; $display("FAIL reset_state: got %h want %h", got, {3'b010, 16'h0, 3'b000});
      end
   endtask

   task automatic test_single();
      int   e;
      exp_t want, got;
      for (int i = 0; i < 17; i++) begin
         send(single_tab[i].o, single_tab[i].x, single_tab[i].y, single_tab[i].s);
         wait_out(e);
         got = observed(); want = sb.pop_front();
         checks++;
         if (e !== 0) begin errors++; $display("FAIL single_latency[%0d]: got %0d want 0", i, e); end
         checks++;
         if (got !== want) begin
            errors++; $display("FAIL single_result[%0d]: got %h want %h", i, got, want);
         end
         if (i < 4) begin
            checks++;
            if (got !== single_pin[i]) begin
               errors++; $display("FAIL single_pin[%0d]: got %h want %h", i, got, single_pin[i]);
            end
         end
      end
   endtask

   task automatic test_mul();
      int   e;
      bit   bad;
      exp_t want, got;
      for (int i = 0; i < 4; i++) begin
         send(mul_tab[i].o, mul_tab[i].x, mul_tab[i].y, mul_tab[i].s);
         a = 8'h55; b = 8'hAA; op = 6'd0;  // must be ignored after acceptance
         e = 0; bad = 1'b0;
         #1;
         while (!out_valid && e < 40) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
            @(negedge clk); #1; e++;
         end
         got = observed(); want = sb.pop_front();
         checks++;
         if (e !== 9) begin errors++; $display("FAIL mul_latency[%0d]: got %0d want 9", i, e); end
         checks++;
         if (bad) begin errors++; $display("FAIL mul_busy[%0d]: got busy/in_ready wrong want 1/0", i); end
         checks++;
         if (got !== want) begin
            errors++; $display("FAIL mul_result[%0d]: got %h want %h", i, got, want);
         end
         if (i < 3) begin
            checks++;
            if (got !== mul_pin[i]) begin
               errors++; $display("FAIL mul_pin[%0d]: got %h want %h", i, got, mul_pin[i]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int   e;
      bit   bad = 1'b0;
      exp_t want, got, snap;
      @(negedge clk);
      out_ready = 1'b0;
      send(6'd0, 8'h10, 8'h20, 3'd0);
      wait_out(e);
      snap = observed(); want = sb.pop_front();
      checks++;
      if (snap !== want) begin errors++; $display("FAIL bp_first: got %h want %h", snap, want); end
      repeat (3) begin
         @(negedge clk); #1;
         if (observed() !== snap || in_ready !== 1'b0 || out_valid !== 1'b1) bad = 1'b1;
      end
      checks++;
      if (bad) begin errors++; $display("FAIL bp_hold: got unstable output want held %h", snap); end
      out_ready = 1'b1;
      send(6'd0, 8'h01, 8'h02, 3'd0);
      wait_out(e);
      got = observed(); want = sb.pop_front();
      checks++;
      if (e !== 0) begin errors++; $display("FAIL bp_release_latency: got %0d want 0", e); end
      checks++;
      if (got !== want) begin errors++; $display("FAIL bp_release: got %h want %h", got, want); end
   endtask

   task automatic test_back_to_back();
      int   e;
      time  t0;
      exp_t want, got;
      t0 = $time;
      for (int i = 0; i < 5; i++) begin
         send(6'(i), 8'(8'h31 * i + 3), 8'(8'h17 + i), 3'(i));
         wait_out(e);
         got = observed(); want = sb.pop_front();
         checks++;
         if (got !== want) begin errors++; $display("FAIL b2b[%0d]: got %h want %h", i, got, want); end
      end
      checks++;
      if (($time - t0) !== 50) begin
         errors++; $display("FAIL b2b_rate: got %0t want 50 time units for 5 ops", $time - t0);
      end
   endtask

   task automatic test_mul_reset();
      int          e;
      bit          bad = 1'b0;
      logic [18:0] got;
      exp_t        want, res;
      send(6'd8, 8'h0B, 8'h0D, 3'd0);
      void'(sb.pop_back());  // aborted, never produces output
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      got = {out_valid, busy, in_ready, result, result_hi};
      checks++;
      if (got !== {3'b001, 16'h0}) begin
         errors++; $display("FAIL mul_abort: got %h want %h", got, {3'b001, 16'h0});
      end
      repeat (12) begin
         @(negedge clk); #1;
         if (out_valid !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin errors++; $display("FAIL mul_abort_quiet: got out_valid 1 want 0"); end
      send(6'd8, 8'h03, 8'h04, 3'd0);
      wait_out(e);
      res = observed(); want = sb.pop_front();
      checks++;
      if (res !== want || res !== {8'h00, 8'h0C, 3'b000} || e !== 9) begin
         errors++; $display("FAIL mul_after_reset: got %h/%0d want %h/9", res, e, want);
      end
   endtask

   task automatic test_random();
      int    e;
      stim_t s;
      exp_t  want, got;
      for (int i = 0; i < 24; i++) begin
         s.o = ($urandom_range(0, 15) == 15) ? 6'h3F : 6'($urandom_range(0, 14));
         s.x = 8'($urandom); s.y = 8'($urandom); s.s = 3'($urandom);
         send(s.o, s.x, s.y, s.s);
         wait_out(e);
         got = observed(); want = sb.pop_front();
         checks++;
         if (got !== want) begin
            errors++; $display("FAIL random[%0d] op %0d: got %h want %h", i, s.o, got, want);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_mul();
      test_backpressure();
      test_back_to_back();
      test_mul_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
